// File: rtl/usr_access_reader.sv
// Reads a user-access register across a clock-domain boundary: synchronizes the
// primitive's CFGCLK/DATAVALID, locks on a stable value, decodes a timestamp and serves reads.
module usr_access_reader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MATCH_COUNT = 3,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfgclk,
  input  logic        datavalid,
  input  logic [31:0] data,
  input  logic        clr,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        valid,
  output logic        err,
  output logic [4:0]  ts_day,
  output logic [3:0]  ts_month,
  output logic [5:0]  ts_year,
  output logic [4:0]  ts_hour,
  output logic [5:0]  ts_min,
  output logic [5:0]  ts_sec
);

  localparam logic [3:0]  MatchTarget   = 4'(MATCH_COUNT);
  localparam logic [19:0] TimeoutTarget = 20'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAcq, StLocked, StFault} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cfg_sync_q, dv_sync_q;
  logic                   cfg_prev_q;
  logic [31:0]            cand_q, cand_d;
  logic [31:0]            capt_q, capt_d;
  logic [3:0]             match_q, match_d;
  logic [19:0]            to_q, to_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   armed_q, rd_ack_q;
  logic [31:0]            rd_data_q;

  logic cfg_s, dv_s, cfg_edge, qual, timeout_hit;
  logic [3:0] match_inc;

  assign cfg_s       = cfg_sync_q[SYNC_STAGES-1];
  assign dv_s        = dv_sync_q[SYNC_STAGES-1];
  assign cfg_edge    = cfg_s & ~cfg_prev_q;
  assign qual        = cfg_edge & dv_s;
  assign timeout_hit = (to_q >= TimeoutTarget);
  assign match_inc   = match_q + 4'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_sync_q <= '0;
      dv_sync_q  <= '0;
      cfg_prev_q <= 1'b0;
    end else begin
      cfg_sync_q <= {cfg_sync_q[SYNC_STAGES-2:0], cfgclk};
      dv_sync_q  <= {dv_sync_q[SYNC_STAGES-2:0], datavalid};
      cfg_prev_q <= cfg_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    capt_d  = capt_q;
    match_d = match_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (cfg_edge) begin
      to_d = '0;
    end else begin
      to_d = (to_q == '1) ? to_q : to_q + 20'd1;
    end

    if (clr) begin
      state_d = StIdle;
      cand_d  = '0;
      capt_d  = '0;
      match_d = '0;
      to_d    = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (timeout_hit) begin
            state_d = StFault;
            err_d   = 1'b1;
          end else if (qual) begin
            cand_d  = data;
            match_d = 4'd1;
            if (MatchTarget == 4'd1) begin
              state_d = StLocked;
              capt_d  = data;
              valid_d = 1'b1;
            end else begin
              state_d = StAcq;
            end
          end
        end
        StAcq: begin
          if (timeout_hit) begin
            state_d = StFault;
            err_d   = 1'b1;
          end else if (qual) begin
            if (data == cand_q) begin
              match_d = match_inc;
              if (match_inc == MatchTarget) begin
                state_d = StLocked;
                capt_d  = cand_q;
                valid_d = 1'b1;
              end
            end else begin
              cand_d  = data;
              match_d = 4'd1;
            end
          end else if (cfg_edge) begin
            // Edge without DATAVALID means the primitive dropped its data: start over.
            state_d = StIdle;
            match_d = '0;
          end
        end
        StLocked: begin
          if (qual && (data != capt_q)) begin
            err_d = 1'b1;
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cand_q  <= '0;
      capt_q  <= '0;
      match_q <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      capt_q  <= capt_d;
      match_q <= match_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Handshake is independent of clr so an ack in flight completes with pre-clear data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed_q   <= 1'b1;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else if (rd_req && armed_q) begin
      armed_q   <= 1'b0;
      rd_ack_q  <= 1'b1;
      rd_data_q <= valid_q ? capt_q : 32'h0;
    end else begin
      rd_ack_q <= 1'b0;
      if (!rd_req) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rd_ack   = rd_ack_q;
  assign rd_data  = rd_data_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign ts_day   = valid_q ? capt_q[31:27] : '0;
  assign ts_month = valid_q ? capt_q[26:23] : '0;
  assign ts_year  = valid_q ? capt_q[22:17] : '0;
  assign ts_hour  = valid_q ? capt_q[16:12] : '0;
  assign ts_min   = valid_q ? capt_q[11:6]  : '0;
  assign ts_sec   = valid_q ? capt_q[5:0]   : '0;

endmodule

// File: tb/tb_usr_access_reader.sv
// Bench for usr_access_reader: directed CFGCLK pulse trains, an event-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_usr_access_reader;

  localparam int unsigned S  = 2;
  localparam int unsigned MC = 3;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0, rstn = 1'b1, cfgclk = 1'b0, datavalid = 1'b0, clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] data = '0;
  logic        rd_ack, valid, err;
  logic [31:0] rd_data;
  logic [4:0]  ts_day, ts_hour;
  logic [3:0]  ts_month;
  logic [5:0]  ts_year, ts_min, ts_sec;

  usr_access_reader #(.SYNC_STAGES(S), .MATCH_COUNT(MC), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .cfgclk(cfgclk), .datavalid(datavalid), .data(data),
    .clr(clr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .valid(valid),
    .err(err), .ts_day(ts_day), .ts_month(ts_month), .ts_year(ts_year),
    .ts_hour(ts_hour), .ts_min(ts_min), .ts_sec(ts_sec)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  function automatic logic [31:0] cap_word();
    return {ts_day, ts_month, ts_year, ts_hour, ts_min, ts_sec};
  endfunction

  function automatic logic [63:0] fld(input logic [31:0] v, input int lo, input int w);
    return 64'((v >> lo) % (32'd1 << w));
  endfunction

  // Reference model: delay lines for the synchronizers, then lock/fault rules as plain counts.
  logic [S:0]  m_cfg = '0, m_dv = '0;
  int          m_idle = 0, m_matches = 0;
  logic [31:0] m_cand = '0, m_capt = '0, m_rdata = '0;
  bit          m_locked = 0, m_faulted = 0, m_err = 0, m_ack = 0, m_armed = 1;

  task automatic model_reset();
    m_cfg = '0; m_dv = '0; m_idle = 0; m_matches = 0; m_cand = '0; m_capt = '0;
    m_rdata = '0; m_locked = 0; m_faulted = 0; m_err = 0; m_ack = 0; m_armed = 1;
  endtask

  task automatic model_step();
    bit ed, q, fault_now;
    ed = m_cfg[S-1] && !m_cfg[S];
    q  = ed && m_dv[S-1];
    if (rd_req && m_armed) begin
      m_ack = 1; m_armed = 0; m_rdata = m_locked ? m_capt : 32'h0;
    end else begin
      m_ack = 0;
      if (!rd_req) m_armed = 1;
    end
    fault_now = !m_locked && !m_faulted && (m_idle >= int'(TO));
    if (clr) begin
      m_cand = '0; m_capt = '0; m_matches = 0; m_locked = 0; m_faulted = 0;
      m_err = 0; m_idle = 0;
    end else begin
      if (m_faulted) begin
      end else if (m_locked) begin
        if (q && data != m_capt) m_err = 1;
      end else if (fault_now) begin
        m_faulted = 1; m_err = 1;
      end else if (q) begin
        if (m_matches > 0 && data == m_cand) m_matches++;
        else begin m_cand = data; m_matches = 1; end
        if (m_matches == int'(MC)) begin m_locked = 1; m_capt = m_cand; end
      end else if (ed) begin
        m_matches = 0;
      end
      if (ed) m_idle = 0;
      else if (m_idle < 1048575) m_idle++;
    end
    m_cfg = {m_cfg[S-1:0], cfgclk};
    m_dv  = {m_dv[S-1:0], datavalid};
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) model_reset();
    else model_step();
  end

  bit mon = 0;
  initial forever begin
    @(negedge clk);
    if (mon) begin
      chk("m_valid", 64'(valid), 64'(m_locked));
      chk("m_err", 64'(err), 64'(m_err));
      chk("m_rd_ack", 64'(rd_ack), 64'(m_ack));
      chk("m_rd_data", 64'(rd_data), 64'(m_rdata));
      chk("m_ts_day", 64'(ts_day), m_locked ? fld(m_capt, 27, 5) : 64'd0);
      chk("m_ts_month", 64'(ts_month), m_locked ? fld(m_capt, 23, 4) : 64'd0);
      chk("m_ts_year", 64'(ts_year), m_locked ? fld(m_capt, 17, 6) : 64'd0);
      chk("m_ts_hour", 64'(ts_hour), m_locked ? fld(m_capt, 12, 5) : 64'd0);
      chk("m_ts_min", 64'(ts_min), m_locked ? fld(m_capt, 6, 6) : 64'd0);
      chk("m_ts_sec", 64'(ts_sec), m_locked ? fld(m_capt, 0, 6) : 64'd0);
    end
  end

  // One CFGCLK period of 7 CLK cycles: 3 high, 4 low.
  task automatic pulse(input logic [31:0] d, input logic v);
    @(negedge clk);
    data = d; datavalid = v; cfgclk = 1'b1;
    repeat (3) @(negedge clk);
    cfgclk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  localparam logic [31:0] K = 32'h5A3C_2E41;
  localparam logic [31:0] R = 32'h1234_5678;
  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;
  localparam logic [31:0] X = 32'h0F0F_1234;
  localparam logic [31:0] Y = 32'h8421_7E5D;

  initial begin
    int n;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    mon = 1;
    rstn = 1'b1;

    // Constant value, lock after three edges, timestamp decode.
    pulse(K, 1'b1); pulse(K, 1'b1);
    chk("k_not_yet", 64'(valid), 64'd0);
    pulse(K, 1'b1);
    chk("k_valid", 64'(valid), 64'd1);
    chk("k_day", 64'(ts_day), 64'd11);
    chk("k_month", 64'(ts_month), 64'd4);
    chk("k_year", 64'(ts_year), 64'd30);
    chk("k_hour", 64'(ts_hour), 64'd2);
    chk("k_min", 64'(ts_min), 64'd57);
    chk("k_sec", 64'(ts_sec), 64'd1);

    // Read handshake: one ack for a held request before lock, then captured data after.
    do_clr();
    @(negedge clk); rd_req = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_ack) n++;
    end
    rd_req = 1'b0;
    chk("rd_one_ack", 64'(n), 64'd1);
    chk("rd_pre_lock", 64'(rd_data), 64'd0);
    pulse(R, 1'b1); pulse(R, 1'b1); pulse(R, 1'b1);
    @(negedge clk); rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
    chk("rd_ack_post", 64'(rd_ack), 64'd1);
    chk("rd_post_lock", 64'(rd_data), 64'(R));

    // A,A,B,B,B locks on B; a later C flags an error without disturbing the capture.
    do_clr();
    pulse(A, 1'b1); pulse(A, 1'b1); pulse(B, 1'b1); pulse(B, 1'b1);
    chk("ab_not_yet", 64'(valid), 64'd0);
    pulse(B, 1'b1);
    chk("ab_valid", 64'(valid), 64'd1);
    chk("ab_capt", 64'(cap_word()), 64'(B));
    pulse(C, 1'b1);
    chk("c_err", 64'(err), 64'd1);
    chk("c_capt", 64'(cap_word()), 64'(B));
    chk("c_valid", 64'(valid), 64'd1);

    // Timeout with CFGCLK idle, then clear.
    do_clr();
    repeat (15) @(negedge clk);
    chk("to_early", 64'(err), 64'd0);
    repeat (5) @(negedge clk);
    chk("to_err", 64'(err), 64'd1);
    chk("to_valid", 64'(valid), 64'd0);
    do_clr();
    chk("to_clr_err", 64'(err), 64'd0);
    chk("to_clr_valid", 64'(valid), 64'd0);

    // Asynchronous reset mid-acquisition discards the two matches.
    do_clr();
    pulse(X, 1'b1); pulse(X, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 64'(valid), 64'd0);
    chk("ar_err", 64'(err), 64'd0);
    chk("ar_rd_data", 64'(rd_data), 64'd0);
    chk("ar_ts", 64'(cap_word()), 64'd0);
    @(negedge clk); rstn = 1'b1;
    pulse(X, 1'b1); pulse(X, 1'b1);
    chk("ar_two", 64'(valid), 64'd0);
    pulse(X, 1'b1);
    chk("ar_lock", 64'(valid), 64'd1);
    chk("ar_capt", 64'(cap_word()), 64'(X));

    // DATAVALID drop after two matches restarts the count.
    do_clr();
    pulse(Y, 1'b1); pulse(Y, 1'b1); pulse(Y, 1'b0);
    pulse(Y, 1'b1); pulse(Y, 1'b1);
    chk("dv_two", 64'(valid), 64'd0);
    pulse(Y, 1'b1);
    chk("dv_lock", 64'(valid), 64'd1);

    // Clear in the same cycle as an accepted request: ack still carries pre-clear data.
    @(negedge clk); rd_req = 1'b1; clr = 1'b1;
    @(negedge clk); rd_req = 1'b0; clr = 1'b0;
    chk("cc_ack", 64'(rd_ack), 64'd1);
    chk("cc_data", 64'(rd_data), 64'(Y));
    chk("cc_valid", 64'(valid), 64'd0);

    repeat (3) @(negedge clk);
    mon = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
